// File: rtl/hwpe_stream_zero_sink_multi_pkg.sv
// Shared types and limits for the multi-channel zero-network fault checker.
package hwpe_stream_zero_sink_multi_pkg;

  // Deepest supported lag between the normal and the zero network.
  localparam int ZS_MAX_DELAY = 8;

  // Storage width of the per-channel event counter; CNT_WIDTH selects the used LSBs.
  localparam int ZS_MAX_CNT_WIDTH = 32;

  // Per-channel fault status: sticky flag plus saturating event count.
  typedef struct packed {
    logic                        fault;
    logic [ZS_MAX_CNT_WIDTH-1:0] cnt;
  } zs_status_t;

endpackage

// File: rtl/hwpe_stream_zero_sink_chan.sv
// One checker channel: lag-matching delay line, valid/strb compare,
// mismatch debounce, sticky fault flag and saturating event counter.
module hwpe_stream_zero_sink_chan
  import hwpe_stream_zero_sink_multi_pkg::*;
#(
  parameter int STRB_WIDTH    = 4,
  parameter int DELAY         = 0,
  parameter int THRESH        = 1,
  parameter int CNT_WIDTH     = 8,
  parameter int STRB_ON_VALID = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  normal_valid_i,
  input  logic                  normal_ready_i,
  input  logic [STRB_WIDTH-1:0] normal_strb_i,
  input  logic                  zero_valid_i,
  input  logic [STRB_WIDTH-1:0] zero_strb_i,
  output logic                  zero_ready_o,
  output logic                  mismatch_o,
  output logic                  fault_o,
  output logic [CNT_WIDTH-1:0]  fault_cnt_o
);

  localparam int RUN_W = $clog2(THRESH) + 1;
  localparam logic [RUN_W-1:0] RUN_THR    = RUN_W'(THRESH);
  localparam logic [RUN_W-1:0] RUN_THR_M1 = RUN_W'(THRESH - 1);
  localparam logic [ZS_MAX_CNT_WIDTH-1:0] CNT_MAX =
    {ZS_MAX_CNT_WIDTH{1'b1}} >> (ZS_MAX_CNT_WIDTH - CNT_WIDTH);

  // Run length saturates at THRESH so a persistent mismatch cannot re-trigger.
  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] r);
    return (r == RUN_THR) ? r : r + 1'b1;
  endfunction

  // Event count saturates at 2^CNT_WIDTH-1.
  function automatic logic [ZS_MAX_CNT_WIDTH-1:0] cnt_inc(input logic [ZS_MAX_CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic                  vld_d;
  logic                  rdy_d;
  logic [STRB_WIDTH-1:0] strb_d;

  generate
    if (DELAY == 0) begin : g_nodly
      assign vld_d  = normal_valid_i;
      assign rdy_d  = normal_ready_i;
      assign strb_d = normal_strb_i;
    end else begin : g_dly
      logic [DELAY-1:0]      vld_p;
      logic [DELAY-1:0]      rdy_p;
      logic [STRB_WIDTH-1:0] strb_p [DELAY];

      // Free-running shift of normal control; ignores enable and clear.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_p <= '0;
          rdy_p <= '0;
          for (int i = 0; i < DELAY; i++) strb_p[i] <= '0;
        end else begin
          // stage 0: sample the normal stream
          vld_p[0]  <= normal_valid_i;
          rdy_p[0]  <= normal_ready_i;
          strb_p[0] <= normal_strb_i;
          // stages 1..DELAY-1: shift toward the zero-network side
          for (int i = 1; i < DELAY; i++) begin
            vld_p[i]  <= vld_p[i-1];
            rdy_p[i]  <= rdy_p[i-1];
            strb_p[i] <= strb_p[i-1];
          end
        end
      end

      assign vld_d  = vld_p[DELAY-1];
      assign rdy_d  = rdy_p[DELAY-1];
      assign strb_d = strb_p[DELAY-1];
    end
  endgenerate

  // The zero network sees the same backpressure as the normal one, lagged.
  assign zero_ready_o = rdy_d;

  logic strb_cmp;
  logic mismatch;
  assign strb_cmp   = (STRB_ON_VALID != 0) ? vld_d : 1'b1;
  assign mismatch   = (zero_valid_i != vld_d) | (strb_cmp & (zero_strb_i != strb_d));
  assign mismatch_o = mismatch;

  logic [RUN_W-1:0] run_q, run_d;
  zs_status_t       status_q, status_d;
  logic             fault_event;

  // Event fires on the THRESH-th consecutive enabled mismatch only.
  assign fault_event = mismatch & enable_i & (run_q == RUN_THR_M1);

  // Next state for the debounce run and the fault status; clear has priority.
  always_comb begin
    run_d    = run_q;
    status_d = status_q;
    if (clear_i) begin
      run_d    = '0;
      status_d = '0;
    end else begin
      run_d = (enable_i && mismatch) ? run_inc(run_q) : '0;
      if (fault_event) begin
        status_d.fault = 1'b1;
        status_d.cnt   = cnt_inc(status_q.cnt);
      end
    end
  end

  // Fault state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q    <= '0;
      status_q <= '0;
    end else begin
      run_q    <= run_d;
      status_q <= status_d;
    end
  end

  assign fault_o     = status_q.fault;
  assign fault_cnt_o = status_q.cnt[CNT_WIDTH-1:0];

endmodule

// File: rtl/hwpe_stream_zero_sink_multi.sv
// Multi-channel zero-network fault checker: terminates NB_CHAN zero streams
// and compares their control against the matching normal streams.
module hwpe_stream_zero_sink_multi
  import hwpe_stream_zero_sink_multi_pkg::*;
#(
  parameter int NB_CHAN       = 2,
  parameter int STRB_WIDTH    = 4,
  parameter int DELAY         = 0,
  parameter int THRESH        = 1,
  parameter int CNT_WIDTH     = 8,
  parameter int STRB_ON_VALID = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic [NB_CHAN-1:0]            normal_valid_i,
  input  logic [NB_CHAN-1:0]            normal_ready_i,
  input  logic [NB_CHAN*STRB_WIDTH-1:0] normal_strb_i,
  input  logic [NB_CHAN-1:0]            zero_valid_i,
  input  logic [NB_CHAN*STRB_WIDTH-1:0] zero_strb_i,
  output logic [NB_CHAN-1:0]            zero_ready_o,
  output logic [NB_CHAN-1:0]            mismatch_o,
  output logic [NB_CHAN-1:0]            fault_o,
  output logic [NB_CHAN*CNT_WIDTH-1:0]  fault_cnt_o,
  output logic                          fault_any_o
);

  generate
    if (DELAY < 0 || DELAY > ZS_MAX_DELAY || THRESH < 1 ||
        CNT_WIDTH < 1 || CNT_WIDTH > ZS_MAX_CNT_WIDTH) begin : g_bad_param
      $error("hwpe_stream_zero_sink_multi: DELAY must be 0..8, THRESH >= 1, CNT_WIDTH 1..32");
    end
  endgenerate

  for (genvar c = 0; c < NB_CHAN; c++) begin : g_chan
    hwpe_stream_zero_sink_chan #(
      .STRB_WIDTH    (STRB_WIDTH),
      .DELAY         (DELAY),
      .THRESH        (THRESH),
      .CNT_WIDTH     (CNT_WIDTH),
      .STRB_ON_VALID (STRB_ON_VALID)
    ) i_chan (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .enable_i       (enable_i),
      .clear_i        (clear_i),
      .normal_valid_i (normal_valid_i[c]),
      .normal_ready_i (normal_ready_i[c]),
      .normal_strb_i  (normal_strb_i[c*STRB_WIDTH +: STRB_WIDTH]),
      .zero_valid_i   (zero_valid_i[c]),
      .zero_strb_i    (zero_strb_i[c*STRB_WIDTH +: STRB_WIDTH]),
      .zero_ready_o   (zero_ready_o[c]),
      .mismatch_o     (mismatch_o[c]),
      .fault_o        (fault_o[c]),
      .fault_cnt_o    (fault_cnt_o[c*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  assign fault_any_o = |fault_o;

endmodule

// File: tb/tb_hwpe_stream_zero_sink_multi.sv
// Bench for hwpe_stream_zero_sink_multi: two configurations side by side,
// u0 (DELAY=3, THRESH=3, STRB_ON_VALID=0) and u1 (DELAY=0, THRESH=1, STRB_ON_VALID=1).
module tb_hwpe_stream_zero_sink_multi;

  localparam int NC = 2;
  localparam int SW = 4;
  localparam int CW = 2;
  localparam int HD = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           en  [2];
  logic           clr [2];
  logic [NC-1:0]  nv  [2];
  logic [NC-1:0]  nr  [2];
  logic [NC*SW-1:0] ns [2];
  logic [NC-1:0]  zv  [2];
  logic [NC*SW-1:0] zs [2];
  logic [NC-1:0]  zr  [2];
  logic [NC-1:0]  mm  [2];
  logic [NC-1:0]  flt [2];
  logic [NC*CW-1:0] cnt [2];
  logic           any [2];

  hwpe_stream_zero_sink_multi #(
    .NB_CHAN(NC), .STRB_WIDTH(SW), .DELAY(3), .THRESH(3), .CNT_WIDTH(CW), .STRB_ON_VALID(0)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en[0]), .clear_i(clr[0]),
    .normal_valid_i(nv[0]), .normal_ready_i(nr[0]), .normal_strb_i(ns[0]),
    .zero_valid_i(zv[0]), .zero_strb_i(zs[0]), .zero_ready_o(zr[0]),
    .mismatch_o(mm[0]), .fault_o(flt[0]), .fault_cnt_o(cnt[0]), .fault_any_o(any[0])
  );

  hwpe_stream_zero_sink_multi #(
    .NB_CHAN(NC), .STRB_WIDTH(SW), .DELAY(0), .THRESH(1), .CNT_WIDTH(CW), .STRB_ON_VALID(1)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en[1]), .clear_i(clr[1]),
    .normal_valid_i(nv[1]), .normal_ready_i(nr[1]), .normal_strb_i(ns[1]),
    .zero_valid_i(zv[1]), .zero_strb_i(zs[1]), .zero_ready_o(zr[1]),
    .mismatch_o(mm[1]), .fault_o(flt[1]), .fault_cnt_o(cnt[1]), .fault_any_o(any[1])
  );

  // Reference model state: history of normal control (index 0 = previous cycle).
  logic          hv [2][NC][HD];
  logic          hr [2][NC][HD];
  logic [SW-1:0] hs [2][NC][HD];
  int            run  [2][NC];
  logic          mflt [2][NC];
  int            mcnt [2][NC];

  typedef struct {
    int            k;
    logic [NC-1:0] mm;
    logic [NC-1:0] zr;
    logic [NC-1:0] flt;
    logic [NC*CW-1:0] cnt;
    logic          any;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int dly_of(int k);  return (k == 0) ? 3 : 0; endfunction
  function automatic int thr_of(int k);  return (k == 0) ? 3 : 1; endfunction
  function automatic logic sov_of(int k); return (k == 0) ? 1'b0 : 1'b1; endfunction

  function automatic void dly_vals(input int k, input int c, output logic v,
                                   output logic [SW-1:0] s, output logic r);
    if (dly_of(k) == 0) begin
      v = nv[k][c]; s = ns[k][c*SW +: SW]; r = nr[k][c];
    end else begin
      v = hv[k][c][dly_of(k)-1]; s = hs[k][c][dly_of(k)-1]; r = hr[k][c][dly_of(k)-1];
    end
  endfunction

  function automatic logic mm_of(int k, int c);
    logic v, r;
    logic [SW-1:0] s;
    dly_vals(k, c, v, s, r);
    return (zv[k][c] !== v) || ((sov_of(k) ? v : 1'b1) && (zs[k][c*SW +: SW] !== s));
  endfunction

  function automatic exp_t model_exp(int k);
    exp_t e;
    logic v, r;
    logic [SW-1:0] s;
    e.k = k; e.mm = '0; e.zr = '0; e.flt = '0; e.cnt = '0; e.any = 1'b0;
    for (int c = 0; c < NC; c++) begin
      dly_vals(k, c, v, s, r);
      e.mm[c]  = mm_of(k, c);
      e.zr[c]  = r;
      e.flt[c] = mflt[k][c];
      e.cnt[c*CW +: CW] = CW'(mcnt[k][c]);
      e.any = e.any | mflt[k][c];
    end
    return e;
  endfunction

  task automatic model_update(int k);
    logic m;
    for (int c = 0; c < NC; c++) begin
      m = mm_of(k, c);
      if (clr[k]) begin
        run[k][c] = 0; mflt[k][c] = 1'b0; mcnt[k][c] = 0;
      end else if (!en[k] || !m) begin
        run[k][c] = 0;
      end else begin
        run[k][c]++;
        if (run[k][c] == thr_of(k)) begin
          mflt[k][c] = 1'b1;
          if (mcnt[k][c] < 3) mcnt[k][c]++;
        end
      end
      for (int i = HD-1; i > 0; i--) begin
        hv[k][c][i] = hv[k][c][i-1]; hr[k][c][i] = hr[k][c][i-1]; hs[k][c][i] = hs[k][c][i-1];
      end
      hv[k][c][0] = nv[k][c]; hr[k][c][0] = nr[k][c]; hs[k][c][0] = ns[k][c*SW +: SW];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NC; c++) begin
        run[k][c] = 0; mflt[k][c] = 1'b0; mcnt[k][c] = 0;
        for (int i = 0; i < HD; i++) begin
          hv[k][c][i] = 1'b0; hr[k][c][i] = 1'b0; hs[k][c][i] = '0;
        end
      end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: push expectations, compare before the edge, then advance the model.
  task automatic step();
    exp_t e;
    for (int k = 0; k < 2; k++) sb.push_back(model_exp(k));
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("u%0d.mismatch", e.k),   8'(mm[e.k]),  8'(e.mm));
      chk($sformatf("u%0d.zero_ready", e.k), 8'(zr[e.k]),  8'(e.zr));
      chk($sformatf("u%0d.fault", e.k),      8'(flt[e.k]), 8'(e.flt));
      chk($sformatf("u%0d.fault_cnt", e.k),  8'(cnt[e.k]), 8'(e.cnt));
      chk($sformatf("u%0d.fault_any", e.k),  8'(any[e.k]), 8'(e.any));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
  endtask

  task automatic drive_match(int k, int c);
    nv[k][c] = 1'($urandom);
    nr[k][c] = 1'($urandom);
    ns[k][c*SW +: SW] = 4'($urandom);
    if (dly_of(k) == 0) begin
      zv[k][c] = nv[k][c]; zs[k][c*SW +: SW] = ns[k][c*SW +: SW];
    end else begin
      zv[k][c] = hv[k][c][dly_of(k)-1]; zs[k][c*SW +: SW] = hs[k][c][dly_of(k)-1];
    end
  endtask

  task automatic drive_all_match();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NC; c++) drive_match(k, c);
  endtask

  task automatic drive_idle();
    for (int k = 0; k < 2; k++) begin
      nv[k] = '0; nr[k] = '0; ns[k] = '0; zv[k] = '0; zs[k] = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin en[k] = 1'b0; clr[k] = 1'b0; end
    drive_idle();
    model_reset();
    #12;
    step();
    step();
    rst_n = 1'b1;
    en[0] = 1'b1; en[1] = 1'b1;

    // matched streams with random backpressure
    repeat (40) begin drive_all_match(); step(); end

    // u0 ch0 lags by 2 instead of 3 cycles
    for (int i = 0; i < 10; i++) begin
      drive_all_match();
      nv[0][0] = 1'b1; ns[0][3:0] = 4'(i);
      zv[0][0] = hv[0][0][1]; zs[0][3:0] = hs[0][0][1];
      step();
    end
    chk("u0.lag_fault", 8'(flt[0]), 8'h01);
    chk("u0.lag_cnt",   8'(cnt[0]), 8'h01);
    drive_all_match(); clr[0] = 1'b1; step(); clr[0] = 1'b0;
    chk("u0.clear_fault", 8'(flt[0]), 8'h00);

    // u0 ch1: 2-cycle strb glitch stays below THRESH, 4-cycle one does not
    for (int i = 0; i < 2; i++) begin drive_all_match(); zs[0][7:4] = zs[0][7:4] ^ 4'h1; step(); end
    repeat (2) begin drive_all_match(); step(); end
    chk("u0.short_glitch_fault", 8'(flt[0]), 8'h00);
    for (int i = 0; i < 4; i++) begin drive_all_match(); zs[0][7:4] = zs[0][7:4] ^ 4'h1; step(); end
    drive_all_match(); step();
    chk("u0.long_glitch_fault", 8'(flt[0]), 8'h02);
    chk("u0.long_glitch_cnt",   8'(cnt[0]), 8'h04);
    drive_all_match(); clr[0] = 1'b1; step(); clr[0] = 1'b0;

    // u1 ch0: five isolated valid mismatches saturate a 2-bit count
    for (int i = 0; i < 5; i++) begin
      drive_all_match(); zv[1][0] = ~nv[1][0]; step();
      drive_all_match(); step();
    end
    chk("u1.sat_cnt",   8'(cnt[1]), 8'h03);
    chk("u1.sat_fault", 8'(flt[1]), 8'h01);
    drive_all_match(); zv[1][0] = ~nv[1][0]; clr[1] = 1'b1; step(); clr[1] = 1'b0;
    chk("u1.clear_wins_fault", 8'(flt[1]), 8'h00);
    chk("u1.clear_wins_cnt",   8'(cnt[1]), 8'h00);

    // u1 ch1: strb compare qualified by valid
    drive_all_match(); nv[1][1] = 1'b0; zv[1][1] = 1'b0; zs[1][7:4] = ~ns[1][7:4];
    #1;
    chk("u1.strb_novalid_mm", 8'(mm[1][1]), 8'h00);
    step();
    drive_all_match(); nv[1][1] = 1'b1; zv[1][1] = 1'b1; zs[1][7:4] = ~ns[1][7:4];
    #1;
    chk("u1.strb_valid_mm", 8'(mm[1][1]), 8'h01);
    step();
    chk("u1.strb_valid_fault", 8'(flt[1]), 8'h02);

    // disabled: mismatches reported, state held
    en[0] = 1'b0; en[1] = 1'b0;
    repeat (10) begin
      drive_all_match(); zv[0] = ~zv[0]; zv[1] = ~zv[1];
      step();
    end
    chk("u0.disabled_fault", 8'(flt[0]), 8'h00);
    chk("u1.disabled_fault", 8'(flt[1]), 8'h02);
    chk("u1.disabled_cnt",   8'(cnt[1]), 8'h04);

    // asynchronous reset mid-cycle
    en[0] = 1'b1; en[1] = 1'b1;
    drive_idle();
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.rst_fault", k), 8'(flt[k]), 8'h00);
      chk($sformatf("u%0d.rst_cnt", k),   8'(cnt[k]), 8'h00);
      chk($sformatf("u%0d.rst_any", k),   8'(any[k]), 8'h00);
      chk($sformatf("u%0d.rst_mm", k),    8'(mm[k]),  8'h00);
    end
    model_reset();
    #4;
    rst_n = 1'b1;
    repeat (6) begin drive_all_match(); step(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
